sample_clk_div: RTL and testbench
=================================

Name: sample_clk_div

Overview:
- Programmable clock divider and sample strobe generator. Sits directly downstream of freq_ctrl and consumes its half_num_clk_cycles output.
- Produces a 50%-duty divided clock, div_clk, whose half-period is that many clk cycles. Also produces a one-cycle tick on each div_clk rising edge, which drives the audio sample fetch.
- A new half-period value is adopted only at a full-period boundary, so speed changes never produce a runt or glitched period.

Parameters:
- WIDTH, 16, width of the half-period input, counter and cur_half.
- MIN_HALF, 2, minimum accepted half-period in clk cycles; smaller inputs are clamped up to it. Must be at least 1.

Ports:
- clk  in  1  system clock; all logic is in this domain.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low freezes the divider.
- half_num_clk_cycles  in  WIDTH  requested half-period in clk cycles, driven from freq_ctrl.
- div_clk  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse, asserted in the same cycle div_clk goes 0->1.
- period_update  out  1  one-cycle pulse when cur_half is (re)loaded with a different value, or on the first load.
- cur_half  out  WIDTH  half-period currently in effect, after clamping.

Behaviour:
- Reset (async, rst=1), all registers cleared immediately:
  - state=IDLE, cnt=0, div_clk=0, tick=0, period_update=0, cur_half=0.
- Clamp: clamp(x) = (x < MIN_HALF) ? MIN_HALF : x.
- States: IDLE, RUN.
- IDLE:
  - en=0: hold all outputs; tick=0, period_update=0.
  - en=1 at an edge: cur_half <= clamp(input), cnt <= 0, period_update <= 1, state <= RUN. div_clk stays 0.
- RUN, en=1, on each edge:
  - If cnt != cur_half-1: cnt <= cnt+1.
  - Else (terminal count): cnt <= 0 and div_clk <= ~div_clk.
    - Old div_clk=0: tick <= 1.
    - Old div_clk=1 (full period complete): cur_half <= clamp(input). period_update <= 1 only if the new value differs from the old cur_half.
- RUN, en=0: cnt, div_clk and cur_half hold; tick=0, period_update=0. Resumes counting where it left off when en returns to 1; state stays RUN.
- tick and period_update are high for exactly one cycle per event and are 0 otherwise.
- Period: each half-period is exactly cur_half enabled cycles, so a full period is 2*cur_half.
  - First rising edge of div_clk occurs cur_half edges after the IDLE->RUN edge.
  - Input changes mid-period are ignored until the next falling transition of div_clk; the whole following period uses the new value.
- Arithmetic:
  - cnt is WIDTH bits and compares against cur_half-1. cur_half is never below 1, so there is no underflow.
  - Input 16'hFFFF is legal: half-period 65535, no overflow.
- The input is sampled only at load points and is expected to be stable (same clk domain). No internal synchroniser is required.
- Reset mid-operation: div_clk drops to 0 asynchronously and no tick is generated. After release the block restarts from IDLE.

Test Plan:
- Reset then en=1, input=3 -> period_update pulses on the load edge, cur_half=3. div_clk first rises 3 edges later, then toggles every 3 cycles (period 6). tick high 1 cycle every 6.
- Running at 3, input changed to 5 while div_clk=1, one cycle after it rose -> current high phase still lasts 3 cycles. On the falling edge cur_half=5 and period_update pulses. Next low and high phases are 5 cycles each.
- Input=0, then input=1 (MIN_HALF=2) -> cur_half=2, period 4. Changing 0->1 produces no period_update, because the clamped value is unchanged.
- en deasserted for 7 cycles mid high phase with cnt=1 -> div_clk stays 1, cnt holds 1, no tick. After re-enable, the remaining 1 cycle of high phase completes (total high time 3 enabled cycles).
- Input=16'h2af8 (11000) -> tick interval exactly 22000 cycles over 3 consecutive ticks, div_clk duty exactly 11000/11000.
- rst pulsed while div_clk=1 and cnt=2 -> div_clk=0, tick=0, cur_half=0 immediately. After release with en=1, the first load reproduces the startup timing.

Source files
------------

// File: rtl/sample_clk_div.sv
// Programmable 50%-duty clock divider with a sample tick on each div_clk rising edge.
// A new half-period is adopted only at a full-period boundary, so periods are never glitched.
module sample_clk_div #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MIN_HALF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] half_num_clk_cycles,
    output logic             div_clk,
    output logic             tick,
    output logic             period_update,
    output logic [WIDTH-1:0] cur_half
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] MinHalf = WIDTH'(MIN_HALF);
    localparam logic [WIDTH-1:0] One     = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] half_q, half_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             pu_q, pu_d;
    logic [WIDTH-1:0] clamped;

    assign clamped = (half_num_clk_cycles < MinHalf) ? MinHalf : half_num_clk_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            half_q  <= '0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
            pu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            pu_q    <= pu_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        pu_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    half_d  = clamped;
                    cnt_d   = '0;
                    pu_d    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (en) begin
                    // half_q is at least 1 here, so half_q - 1 cannot underflow
                    if (cnt_q != half_q - One) begin
                        cnt_d = cnt_q + One;
                    end else begin
                        cnt_d = '0;
                        div_d = ~div_q;
                        if (!div_q) begin
                            tick_d = 1'b1;
                        end else begin
                            half_d = clamped;
                            pu_d   = (clamped != half_q);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign div_clk       = div_q;
    assign tick          = tick_q;
    assign period_update = pu_q;
    assign cur_half      = half_q;

endmodule

// File: tb/tb_sample_clk_div.sv
// Directed self-checking bench for sample_clk_div: startup, rate change, clamp,
// enable freeze, long period and mid-operation reset.
module tb_sample_clk_div;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] half_num_clk_cycles;
    logic        div_clk;
    logic        tick;
    logic        period_update;
    logic [15:0] cur_half;

    int checks = 0;
    int errors = 0;

    sample_clk_div #(
        .WIDTH   (16),
        .MIN_HALF(2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .half_num_clk_cycles(half_num_clk_cycles),
        .div_clk            (div_clk),
        .tick               (tick),
        .period_update      (period_update),
        .cur_half           (cur_half)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until tick is seen; n = edges taken, or -1 if the budget runs out.
    task automatic wait_tick(output int n, input int budget);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < budget);
        if (!tick) n = -1;
    endtask

    task automatic wait_fall(output int n, input int budget);
        n = 0;
        do begin
            step();
            n++;
        end while (div_clk && n < budget);
        if (div_clk) n = -1;
    endtask

    int n;
    int saw_tick;
    int saw_low;

    initial begin
        rst = 1'b1;
        en = 1'b0;
        half_num_clk_cycles = 16'd3;
        #12;
        check("rst_div_clk", int'(div_clk), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_pu", int'(period_update), 0);
        check("rst_cur_half", int'(cur_half), 0);

        // Startup at half-period 3
        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle_hold_pu", int'(period_update), 0);
        en = 1'b1;
        step();
        check("load_pu", int'(period_update), 1);
        check("load_cur_half", int'(cur_half), 3);
        check("load_div_clk", int'(div_clk), 0);
        step();
        check("load_pu_one_cycle", int'(period_update), 0);
        wait_tick(n, 20);
        check("first_rise_edges", n, 2);
        check("first_rise_div_clk", int'(div_clk), 1);
        step();
        check("tick_one_cycle", int'(tick), 0);
        wait_tick(n, 20);
        check("tick_interval_3", n, 5);
        wait_tick(n, 20);
        check("tick_interval_3b", n, 6);

        // Rate change 3 -> 5 one cycle after the rise
        step();
        half_num_clk_cycles = 16'd5;
        wait_fall(n, 20);
        check("high_keeps_3", n, 2);
        check("fall_cur_half_5", int'(cur_half), 5);
        check("fall_pu_5", int'(period_update), 1);
        wait_tick(n, 20);
        check("low_phase_5", n, 5);
        half_num_clk_cycles = 16'd0;
        wait_fall(n, 20);
        check("high_phase_5", n, 5);

        // Clamp: 0 then 1 both give 2
        check("clamp0_cur_half", int'(cur_half), 2);
        check("clamp0_pu", int'(period_update), 1);
        half_num_clk_cycles = 16'd1;
        wait_tick(n, 20);
        check("clamp_low_2", n, 2);
        wait_fall(n, 20);
        check("clamp_high_2", n, 2);
        check("clamp1_cur_half", int'(cur_half), 2);
        check("clamp1_no_pu", int'(period_update), 0);

        // Back to 3, then freeze mid high phase with cnt=1
        half_num_clk_cycles = 16'd3;
        wait_tick(n, 20);
        check("clamp_low_2b", n, 2);
        wait_fall(n, 20);
        check("to3_cur_half", int'(cur_half), 3);
        check("to3_pu", int'(period_update), 1);
        wait_tick(n, 20);
        check("to3_low", n, 3);
        step();
        en = 1'b0;
        saw_tick = 0;
        saw_low = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (tick) saw_tick = 1;
            if (!div_clk) saw_low = 1;
        end
        check("freeze_no_tick", saw_tick, 0);
        check("freeze_div_clk_high", saw_low, 0);
        en = 1'b1;
        wait_fall(n, 20);
        check("freeze_resume_high", n, 2);

        // Long period 11000
        half_num_clk_cycles = 16'h2af8;
        wait_tick(n, 20);
        check("pre_long_low", n, 3);
        wait_fall(n, 20);
        check("pre_long_high", n, 3);
        check("long_cur_half", int'(cur_half), 11000);
        check("long_pu", int'(period_update), 1);
        wait_tick(n, 30000);
        check("long_low", n, 11000);
        wait_fall(n, 30000);
        check("long_high", n, 11000);
        wait_tick(n, 30000);
        check("long_low2", n, 11000);
        wait_tick(n, 30000);
        check("long_tick_interval", n, 22000);

        // Reset while div_clk=1, cnt=2
        half_num_clk_cycles = 16'd3;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_div_clk", int'(div_clk), 0);
        check("midrst_tick", int'(tick), 0);
        check("midrst_cur_half", int'(cur_half), 0);
        #2;
        rst = 1'b0;
        step();
        check("rerun_pu", int'(period_update), 1);
        check("rerun_cur_half", int'(cur_half), 3);
        check("rerun_div_clk", int'(div_clk), 0);
        wait_tick(n, 20);
        check("rerun_first_rise", n, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
